// File: rtl/intr_arbiter.sv
// intr_arbiter
//   Arbitrates the four interrupt sources of the pipelined core and sequences
//   trap entry into the CSR register file. Each source's rising edge is captured
//   into a pending bit. Pending bits are qualified by the per-source masks and the
//   global enable. One trap request at a time goes out over a req/ack handshake,
//   and the granted source stays in service until the handler executes mret.
//
// Ports
//   clk         core clock
//   rst         asynchronous reset, active-high
//   e_inter     external interrupt line   (src 0, rising edge captured)
//   t_inter     timer interrupt line      (src 1, rising edge captured)
//   tx_intr     UART TX-done interrupt    (src 2, rising edge captured)
//   rx_intr     UART RX-ready interrupt   (src 3, rising edge captured)
//   mie         global interrupt enable
//   src_mask    per-source enable, bit i = src i
//   stall       pipeline stall; a new request is not raised while high
//   trap_ack    CSR file accepted the trap
//   is_mret     mret reached the execute stage
//   trap_req    trap request to the CSR file
//   trap_cause  mcause of the current/last granted source
//   trap_id     index of the current/last granted source
//   pending     latched pending bits
//   in_service  a handler is running
//
// Configuration
//   INTR_RR_PRIO_EN defined   : round-robin priority. The search starts at a
//                               pointer that moves past each acknowledged source.
//   INTR_RR_PRIO_EN undefined : fixed priority, src0 > src1 > src2 > src3.

module intr_arbiter #(
    parameter logic [31:0] CAUSE_EXT   = 32'h8000_000B,
    parameter logic [31:0] CAUSE_TMR   = 32'h8000_0007,
    parameter logic [31:0] CAUSE_UTX   = 32'h8000_0010,
    parameter logic [31:0] CAUSE_URX   = 32'h8000_0011,
    parameter int          ACK_TIMEOUT = 16
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        e_inter,
    input  logic        t_inter,
    input  logic        tx_intr,
    input  logic        rx_intr,
    input  logic        mie,
    input  logic [3:0]  src_mask,
    input  logic        stall,
    input  logic        trap_ack,
    input  logic        is_mret,
    output logic        trap_req,
    output logic [31:0] trap_cause,
    output logic [1:0]  trap_id,
    output logic [3:0]  pending,
    output logic        in_service
);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        REQ     = 2'd1,
        SERVICE = 2'd2
    } state_t;

    localparam logic [7:0] ACK_LAST = 8'(ACK_TIMEOUT - 1);

    state_t      state;
    state_t      state_next;
    logic [3:0]  src_now;
    logic [3:0]  src_prev;
    logic [3:0]  src_rise;
    logic [3:0]  eligible;
    logic [3:0]  clear_mask;
    logic [7:0]  ack_count;
    logic        ack_take;
    logic        grant_valid;
    logic [1:0]  grant_id;

    function automatic logic [31:0] cause_of(input logic [1:0] id);
        case (id)
            2'd0:    cause_of = CAUSE_EXT;
            2'd1:    cause_of = CAUSE_TMR;
            2'd2:    cause_of = CAUSE_UTX;
            default: cause_of = CAUSE_URX;
        endcase
    endfunction

    assign src_now  = {rx_intr, tx_intr, t_inter, e_inter};
    assign src_rise = src_now & ~src_prev;
    assign eligible = pending & src_mask & {4{mie}};
    // An ack counts only while a request is outstanding. Stray acks are ignored.
    assign ack_take = (state == REQ) && trap_ack;
    assign clear_mask = ack_take ? (4'b0001 << trap_id) : 4'b0000;

    assign trap_req   = (state == REQ);
    assign in_service = (state == SERVICE);

`ifdef INTR_RR_PRIO_EN
    logic [1:0] rr_ptr;
    logic [1:0] rr_cand;

    // Round-robin search: first eligible source at or after the pointer, wrapping 3->0.
    always_comb begin
        grant_valid = 1'b0;
        grant_id    = rr_ptr;
        rr_cand     = rr_ptr;
        for (int k = 0; k < 4; k++) begin
            rr_cand = rr_ptr + 2'(k);
            if (!grant_valid && eligible[rr_cand]) begin
                grant_valid = 1'b1;
                grant_id    = rr_cand;
            end
        end
    end

    // The pointer moves just past the source whose trap was accepted.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rr_ptr <= 2'd0;
        end else if (ack_take) begin
            rr_ptr <= trap_id + 2'd1;
        end
    end
`else
    // Fixed priority: the lowest-numbered eligible source wins.
    always_comb begin
        grant_valid = |eligible;
        grant_id    = 2'd0;
        if (eligible[0]) begin
            grant_id = 2'd0;
        end else if (eligible[1]) begin
            grant_id = 2'd1;
        end else if (eligible[2]) begin
            grant_id = 2'd2;
        end else if (eligible[3]) begin
            grant_id = 2'd3;
        end
    end
`endif

    // State register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state logic. An outstanding request is never withdrawn because a
    // mask or mie change occurs. Only an ack or the timeout ends it.
    always_comb begin
        state_next = state;
        case (state)
            IDLE: begin
                if (grant_valid && !stall) begin
                    state_next = REQ;
                end
            end
            REQ: begin
                if (trap_ack) begin
                    state_next = SERVICE;
                end else if (ack_count == ACK_LAST) begin
                    state_next = IDLE;
                end
            end
            SERVICE: begin
                if (is_mret) begin
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    // Ack-wait counter. It runs only while the request stays outstanding.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ack_count <= 8'd0;
        end else if ((state == REQ) && (state_next == REQ)) begin
            ack_count <= ack_count + 8'd1;
        end else begin
            ack_count <= 8'd0;
        end
    end

    // Winner is latched on the grant edge and frozen until the next grant.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            trap_id    <= 2'd0;
            trap_cause <= 32'd0;
        end else if ((state == IDLE) && (state_next == REQ)) begin
            trap_id    <= grant_id;
            trap_cause <= cause_of(grant_id);
        end
    end

    // Edge history and pending capture. A new edge overrides a clear on the same cycle.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            src_prev <= 4'd0;
            pending  <= 4'd0;
        end else begin
            src_prev <= src_now;
            pending  <= (pending & ~clear_mask) | src_rise;
        end
    end

endmodule

// File: tb/tb_intr_arbiter.sv
// tb_intr_arbiter
//   Self-checking bench for intr_arbiter. Directed scenarios use constant
//   expectations. A randomized run compares the design every cycle against a
//   behavioural model of the interrupt rules.

module tb_intr_arbiter;

    localparam int ACK_TIMEOUT = 16;

    logic        clk = 1'b0;
    logic        rst;
    logic        e_inter, t_inter, tx_intr, rx_intr;
    logic        mie;
    logic [3:0]  src_mask;
    logic        stall, trap_ack, is_mret;
    logic        trap_req;
    logic [31:0] trap_cause;
    logic [1:0]  trap_id;
    logic [3:0]  pending;
    logic        in_service;

    int checks   = 0;
    int failures = 0;

    // Behavioural model state: phase 0 = no trap, 1 = waiting for ack, 2 = handler running
    bit          m_pend [4];
    bit          m_prev [4];
    int          m_phase;
    int          m_wait;
    logic [1:0]  m_id;
    logic [31:0] m_cause;
`ifdef INTR_RR_PRIO_EN
    int          m_ptr;
`endif

    intr_arbiter dut (
        .clk        (clk),
        .rst        (rst),
        .e_inter    (e_inter),
        .t_inter    (t_inter),
        .tx_intr    (tx_intr),
        .rx_intr    (rx_intr),
        .mie        (mie),
        .src_mask   (src_mask),
        .stall      (stall),
        .trap_ack   (trap_ack),
        .is_mret    (is_mret),
        .trap_req   (trap_req),
        .trap_cause (trap_cause),
        .trap_id    (trap_id),
        .pending    (pending),
        .in_service (in_service)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] spec_cause(input int id);
        case (id)
            0:       spec_cause = 32'h8000_000B;
            1:       spec_cause = 32'h8000_0007;
            2:       spec_cause = 32'h8000_0010;
            default: spec_cause = 32'h8000_0011;
        endcase
    endfunction

    task automatic model_reset();
        for (int i = 0; i < 4; i++) begin
            m_pend[i] = 1'b0;
            m_prev[i] = 1'b0;
        end
        m_phase = 0;
        m_wait  = 0;
        m_id    = 2'd0;
        m_cause = 32'd0;
`ifdef INTR_RR_PRIO_EN
        m_ptr   = 0;
`endif
    endtask

    task automatic model_advance(input logic [3:0] lines, input logic mie_s, input logic [3:0] mask_s,
                                 input logic stall_s, input logic ack_s, input logic mret_s);
        int win;
        int idx;
        int base;
        int clr;
        win = -1;
        clr = -1;
        base = 0;
`ifdef INTR_RR_PRIO_EN
        base = m_ptr;
`endif
        if (m_phase == 0) begin
            if (mie_s) begin
                for (int k = 0; k < 4; k++) begin
                    idx = (base + k) % 4;
                    if (win < 0 && m_pend[idx] && mask_s[idx]) win = idx;
                end
            end
            if (win >= 0 && !stall_s) begin
                m_phase = 1;
                m_wait  = 0;
                m_id    = 2'(win);
                m_cause = spec_cause(win);
            end
        end else if (m_phase == 1) begin
            if (ack_s) begin
                m_phase = 2;
                clr     = int'(m_id);
`ifdef INTR_RR_PRIO_EN
                m_ptr   = (int'(m_id) + 1) % 4;
`endif
            end else if (m_wait == ACK_TIMEOUT - 1) begin
                m_phase = 0;
                m_wait  = 0;
            end else begin
                m_wait = m_wait + 1;
            end
        end else begin
            if (mret_s) m_phase = 0;
        end
        if (clr >= 0) m_pend[clr] = 1'b0;
        for (int i = 0; i < 4; i++) begin
            if (lines[i] && !m_prev[i]) m_pend[i] = 1'b1;
            m_prev[i] = lines[i];
        end
    endtask

    // One clock: inputs seen at the edge feed the model, outputs settle 1 ns later.
    task automatic tick();
        logic [3:0] lines;
        logic       mie_s, stall_s, ack_s, mret_s, rst_s;
        logic [3:0] mask_s;
        lines   = {rx_intr, tx_intr, t_inter, e_inter};
        mie_s   = mie;
        mask_s  = src_mask;
        stall_s = stall;
        ack_s   = trap_ack;
        mret_s  = is_mret;
        rst_s   = rst;
        @(posedge clk);
        #1;
        if (rst_s) model_reset();
        else model_advance(lines, mie_s, mask_s, stall_s, ack_s, mret_s);
    endtask

    task automatic do_reset();
        e_inter  = 1'b0;
        t_inter  = 1'b0;
        tx_intr  = 1'b0;
        rx_intr  = 1'b0;
        mie      = 1'b1;
        src_mask = 4'hF;
        stall    = 1'b0;
        trap_ack = 1'b0;
        is_mret  = 1'b0;
        rst      = 1'b1;
        tick();
        tick();
        rst = 1'b0;
    endtask

    task automatic test_reset();
        do_reset();
        rst = 1'b1;
        #1;
        checks++;
        if ({trap_req, in_service, pending, trap_id, trap_cause} !== 40'd0) begin
            failures++;
            $display("[TB] FAIL reset_outputs: got req=%0b svc=%0b pend=%b id=%0d cause=%h, want all 0",
                     trap_req, in_service, pending, trap_id, trap_cause);
        end
        tick();
        rst = 1'b0;
    endtask

    task automatic test_single_timer();
        do_reset();
        t_inter = 1'b1;
        tick();
        checks++;
        if ({trap_req, pending} !== 5'b0_0010) begin
            failures++;
            $display("[TB] FAIL t1_capture: got req=%0b pend=%b, want req=0 pend=0010", trap_req, pending);
        end
        t_inter = 1'b0;
        tick();
        checks++;
        if ({trap_req, trap_id, trap_cause} !== {1'b1, 2'd1, 32'h8000_0007}) begin
            failures++;
            $display("[TB] FAIL t1_request: got req=%0b id=%0d cause=%h, want req=1 id=1 cause=80000007",
                     trap_req, trap_id, trap_cause);
        end
        tick();
        tick();
        checks++;
        if (trap_req !== 1'b1) begin
            failures++;
            $display("[TB] FAIL t1_hold: got req=%0b, want 1", trap_req);
        end
        trap_ack = 1'b1;
        tick();
        trap_ack = 1'b0;
        checks++;
        if ({trap_req, in_service, pending} !== 6'b01_0000) begin
            failures++;
            $display("[TB] FAIL t1_ack: got req=%0b svc=%0b pend=%b, want req=0 svc=1 pend=0000",
                     trap_req, in_service, pending);
        end
        is_mret = 1'b1;
        tick();
        is_mret = 1'b0;
        checks++;
        if ({trap_req, in_service} !== 2'b00) begin
            failures++;
            $display("[TB] FAIL t1_mret: got req=%0b svc=%0b, want 0 0", trap_req, in_service);
        end
    endtask

    task automatic test_simultaneous();
        do_reset();
        e_inter = 1'b1;
        rx_intr = 1'b1;
        tick();
        e_inter = 1'b0;
        rx_intr = 1'b0;
        checks++;
        if (pending !== 4'b1001) begin
            failures++;
            $display("[TB] FAIL sim_pending: got %b, want 1001", pending);
        end
        tick();
        checks++;
        if ({trap_req, trap_id, trap_cause} !== {1'b1, 2'd0, 32'h8000_000B}) begin
            failures++;
            $display("[TB] FAIL sim_first: got req=%0b id=%0d cause=%h, want req=1 id=0 cause=8000000B",
                     trap_req, trap_id, trap_cause);
        end
        trap_ack = 1'b1;
        tick();
        trap_ack = 1'b0;
        is_mret = 1'b1;
        tick();
        is_mret = 1'b0;
        tick();
        checks++;
        if ({trap_req, trap_id, trap_cause} !== {1'b1, 2'd3, 32'h8000_0011}) begin
            failures++;
            $display("[TB] FAIL sim_second: got req=%0b id=%0d cause=%h, want req=1 id=3 cause=80000011",
                     trap_req, trap_id, trap_cause);
        end
        trap_ack = 1'b1;
        tick();
        trap_ack = 1'b0;
        is_mret = 1'b1;
        tick();
        is_mret = 1'b0;
    endtask

    task automatic test_timeout();
        int n;
        do_reset();
        tx_intr = 1'b1;
        tick();
        tick();
        checks++;
        if ({trap_req, trap_id} !== {1'b1, 2'd2}) begin
            failures++;
            $display("[TB] FAIL to_request: got req=%0b id=%0d, want req=1 id=2", trap_req, trap_id);
        end
        n = trap_req ? 1 : 0;
        for (int c = 0; c < 40 && trap_req; c++) begin
            tick();
            if (trap_req) n++;
        end
        checks++;
        if (n != ACK_TIMEOUT || trap_req !== 1'b0) begin
            failures++;
            $display("[TB] FAIL to_length: got %0d high cycles (req now %0b), want %0d then 0",
                     n, trap_req, ACK_TIMEOUT);
        end
        checks++;
        if (pending[2] !== 1'b1) begin
            failures++;
            $display("[TB] FAIL to_pending: got pend=%b, want bit2=1", pending);
        end
        tick();
        checks++;
        if ({trap_req, trap_id} !== {1'b1, 2'd2}) begin
            failures++;
            $display("[TB] FAIL to_rerequest: got req=%0b id=%0d, want req=1 id=2", trap_req, trap_id);
        end
        tx_intr = 1'b0;
        trap_ack = 1'b1;
        tick();
        trap_ack = 1'b0;
        is_mret = 1'b1;
        tick();
        is_mret = 1'b0;
    endtask

    task automatic test_mask_mie();
        do_reset();
        src_mask = 4'b1110;
        e_inter = 1'b1;
        tick();
        checks++;
        if ({trap_req, pending} !== 5'b0_0001) begin
            failures++;
            $display("[TB] FAIL mask_capture: got req=%0b pend=%b, want req=0 pend=0001", trap_req, pending);
        end
        for (int c = 0; c < 3; c++) begin
            tick();
            checks++;
            if (trap_req !== 1'b0) begin
                failures++;
                $display("[TB] FAIL mask_block: cycle %0d got req=%0b, want 0", c, trap_req);
            end
        end
        src_mask = 4'hF;
        tick();
        checks++;
        if ({trap_req, trap_id} !== {1'b1, 2'd0}) begin
            failures++;
            $display("[TB] FAIL mask_release: got req=%0b id=%0d, want req=1 id=0", trap_req, trap_id);
        end
        e_inter = 1'b0;
        trap_ack = 1'b1;
        tick();
        trap_ack = 1'b0;
        is_mret = 1'b1;
        tick();
        is_mret = 1'b0;
        mie = 1'b0;
        t_inter = 1'b1;
        tick();
        t_inter = 1'b0;
        for (int c = 0; c < 3; c++) begin
            tick();
            checks++;
            if (trap_req !== 1'b0) begin
                failures++;
                $display("[TB] FAIL mie_block: cycle %0d got req=%0b, want 0", c, trap_req);
            end
        end
        checks++;
        if (pending !== 4'b0010) begin
            failures++;
            $display("[TB] FAIL mie_pending: got %b, want 0010", pending);
        end
        mie = 1'b1;
        tick();
        checks++;
        if ({trap_req, trap_id} !== {1'b1, 2'd1}) begin
            failures++;
            $display("[TB] FAIL mie_release: got req=%0b id=%0d, want req=1 id=1", trap_req, trap_id);
        end
        trap_ack = 1'b1;
        tick();
        trap_ack = 1'b0;
        is_mret = 1'b1;
        tick();
        is_mret = 1'b0;
    endtask

    task automatic test_stall_service();
        do_reset();
        stall = 1'b1;
        e_inter = 1'b1;
        tick();
        e_inter = 1'b0;
        for (int c = 0; c < 3; c++) begin
            tick();
            checks++;
            if (trap_req !== 1'b0) begin
                failures++;
                $display("[TB] FAIL stall_block: cycle %0d got req=%0b, want 0", c, trap_req);
            end
        end
        stall = 1'b0;
        tick();
        checks++;
        if ({trap_req, trap_id} !== {1'b1, 2'd0}) begin
            failures++;
            $display("[TB] FAIL stall_release: got req=%0b id=%0d, want req=1 id=0", trap_req, trap_id);
        end
        trap_ack = 1'b1;
        tick();
        trap_ack = 1'b0;
        rx_intr = 1'b1;
        tick();
        rx_intr = 1'b0;
        checks++;
        if ({trap_req, in_service, pending} !== 6'b01_1000) begin
            failures++;
            $display("[TB] FAIL svc_capture: got req=%0b svc=%0b pend=%b, want req=0 svc=1 pend=1000",
                     trap_req, in_service, pending);
        end
        trap_ack = 1'b1;
        tick();
        trap_ack = 1'b0;
        for (int c = 0; c < 3; c++) begin
            tick();
            checks++;
            if ({trap_req, in_service, pending} !== 6'b01_1000) begin
                failures++;
                $display("[TB] FAIL svc_hold: cycle %0d got req=%0b svc=%0b pend=%b, want 0 1 1000",
                         c, trap_req, in_service, pending);
            end
        end
        is_mret = 1'b1;
        tick();
        is_mret = 1'b0;
        checks++;
        if ({trap_req, in_service} !== 2'b00) begin
            failures++;
            $display("[TB] FAIL svc_mret: got req=%0b svc=%0b, want 0 0", trap_req, in_service);
        end
        tick();
        checks++;
        if ({trap_req, trap_id} !== {1'b1, 2'd3}) begin
            failures++;
            $display("[TB] FAIL svc_next: got req=%0b id=%0d, want req=1 id=3", trap_req, trap_id);
        end
        rst = 1'b1;
        #1;
        checks++;
        if ({trap_req, in_service, pending, trap_id, trap_cause} !== 40'd0) begin
            failures++;
            $display("[TB] FAIL async_reset: got req=%0b svc=%0b pend=%b id=%0d cause=%h, want all 0",
                     trap_req, in_service, pending, trap_id, trap_cause);
        end
        tick();
        rst = 1'b0;
    endtask

`ifdef INTR_RR_PRIO_EN
    task automatic test_round_robin();
        do_reset();
        e_inter = 1'b1;
        t_inter = 1'b1;
        tx_intr = 1'b1;
        rx_intr = 1'b1;
        tick();
        e_inter = 1'b0;
        t_inter = 1'b0;
        tx_intr = 1'b0;
        rx_intr = 1'b0;
        for (int k = 0; k < 4; k++) begin
            tick();
            checks++;
            if ({trap_req, trap_id} !== {1'b1, 2'(k)}) begin
                failures++;
                $display("[TB] FAIL rr_order: grant %0d got req=%0b id=%0d, want req=1 id=%0d",
                         k, trap_req, trap_id, k);
            end
            trap_ack = 1'b1;
            tick();
            trap_ack = 1'b0;
            is_mret = 1'b1;
            tick();
            is_mret = 1'b0;
        end
        e_inter = 1'b1;
        t_inter = 1'b1;
        tick();
        e_inter = 1'b0;
        t_inter = 1'b0;
        tick();
        checks++;
        if ({trap_req, trap_id} !== {1'b1, 2'd0}) begin
            failures++;
            $display("[TB] FAIL rr_wrap: got req=%0b id=%0d, want req=1 id=0", trap_req, trap_id);
        end
    endtask
`endif

    task automatic test_random();
        logic [39:0] obs;
        logic [39:0] expv;
        logic [3:0]  exp_pend;
        int          shown;
        shown = 0;
        do_reset();
        for (int c = 0; c < 800; c++) begin
            if ($urandom_range(7) == 0) e_inter = ~e_inter;
            if ($urandom_range(7) == 0) t_inter = ~t_inter;
            if ($urandom_range(7) == 0) tx_intr = ~tx_intr;
            if ($urandom_range(7) == 0) rx_intr = ~rx_intr;
            mie      = ($urandom_range(7) != 0);
            if (c % 32 == 0) src_mask = 4'($urandom_range(15));
            stall    = ($urandom_range(5) == 0);
            trap_ack = ($urandom_range(2) == 0);
            is_mret  = ($urandom_range(3) == 0);
            tick();
            for (int i = 0; i < 4; i++) exp_pend[i] = m_pend[i];
            expv = {(m_phase == 1), (m_phase == 2), exp_pend, m_id, m_cause};
            obs  = {trap_req, in_service, pending, trap_id, trap_cause};
            checks++;
            if (obs !== expv) begin
                failures++;
                if (shown < 10) begin
                    shown++;
                    $display("[TB] FAIL random_cycle %0d: got req/svc/pend/id/cause=%h, want %h", c, obs, expv);
                end
            end
        end
    endtask

    initial begin
        model_reset();
        test_reset();
        test_single_timer();
        test_simultaneous();
        test_timeout();
        test_mask_mie();
        test_stall_service();
`ifdef INTR_RR_PRIO_EN
        test_round_robin();
`endif
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
